cv32e40p_mac_acc: RTL and testbench

Multi-channel, parametrised fixed-point multiply-accumulate engine for CNN dot products. Accepts a stream of signed operand pairs with a valid/ready handshake. Accumulates a programmed number of Qm.FRAC_W products into one of NUM_CH channel accumulators and returns the result with a one-cycle valid pulse. Sits beside the core as an accelerator datapath; the core programs length and channel, streams operands and collects results.

---
 rtl/cv32e40p_mac_acc.sv | 185 ++++++++++++++++++
 tb/tb_cv32e40p_mac_acc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_mac_acc.sv
// Multi-channel fixed-point multiply-accumulate engine (2-stage: product register, accumulate).
// Define CV32E40P_MAC_SAT_EN for saturating accumulation with a sticky sat_o flag; otherwise wrap.
module cv32e40p_mac_acc #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int ACC_W  = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_global_i,
    input  logic              clr_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic              keep_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [ACC_W-1:0]  result_o,
    output logic [CH_W-1:0]   result_ch_o,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [ACC_W-1:0]  rd_data_o,
    output logic              sat_o
);
    localparam int PW = 2 * DATA_W;
    localparam int EW = (PW > ACC_W) ? PW : ACC_W;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} t_state;

    t_state               r_state;
    t_state               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CH_W-1:0]      r_ch;
    logic [CH_W-1:0]      r_result_ch;
    logic                 r_s1_vld;
    logic signed [PW-1:0] r_s1_prod;
    logic [ACC_W-1:0]     r_acc [NUM_CH];
    logic [ACC_W-1:0]     r_result;

    logic                 w_start;
    logic                 w_accept;
    logic                 w_last;
    logic signed [PW-1:0] w_shift;
    logic signed [EW-1:0] w_ext;
    logic [ACC_W-1:0]     w_acc_cur;
    logic [ACC_W-1:0]     w_acc_new;

    assign w_start   = (r_state == S_IDLE) && start_i && !clr_i;
    assign w_accept  = (r_state == S_ACC) && valid_i && !clr_i;
    assign w_last    = w_accept && (r_cnt == CNT_W'(1));
    assign w_shift   = r_s1_prod >>> FRAC_W;
    assign w_ext     = EW'(w_shift);
    assign w_acc_cur = r_acc[r_ch];

`ifdef CV32E40P_MAC_SAT_EN
    localparam logic [ACC_W-1:0] P_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] P_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [EW-ACC_W:0] w_hi;
    logic              w_prod_ovf;
    logic              w_sum_ovf;
    logic [ACC_W-1:0]  w_prod_sat;
    logic [ACC_W:0]    w_sum;
    logic              r_sat;

    // Shifted product fits in ACC_W only if all bits above the result sign agree with it.
    assign w_hi       = w_ext[EW-1:ACC_W-1];
    assign w_prod_ovf = !((&w_hi) || !(|w_hi));
    assign w_prod_sat = w_prod_ovf ? (w_ext[EW-1] ? P_MIN : P_MAX) : w_ext[ACC_W-1:0];
    assign w_sum      = {w_acc_cur[ACC_W-1], w_acc_cur} + {w_prod_sat[ACC_W-1], w_prod_sat};
    assign w_sum_ovf  = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_acc_new  = w_sum_ovf ? (w_sum[ACC_W] ? P_MIN : P_MAX) : w_sum[ACC_W-1:0];

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            r_sat <= 1'b0;
        end else if (clr_i || (w_start && !keep_i)) begin
            r_sat <= 1'b0;
        end else if (r_s1_vld && (w_prod_ovf || w_sum_ovf)) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_o = r_sat;
`else
    assign w_acc_new = w_acc_cur + w_ext[ACC_W-1:0];
    assign sat_o     = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        ready_o        = 1'b0;
        busy_o         = 1'b1;
        result_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nxt = (len_i != '0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                ready_o = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_s1_vld) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                result_valid_o = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (clr_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ch      <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_prod <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_s1_vld <= w_accept;
            if (w_start) begin
                r_cnt <= len_i;
                r_ch  <= ch_i;
            end else if (w_accept) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_accept) begin
                r_s1_prod <= $signed(a_i) * $signed(b_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (clr_i) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            if (w_start && !keep_i) begin
                r_acc[ch_i] <= '0;
            end
            if (r_s1_vld) begin
                r_acc[r_ch] <= w_acc_new;
            end
        end
    end

    // Result is driven live from the accumulator during DONE and latched on leaving it.
    always_ff @(posedge clk_i or negedge rst_n_global_i) begin
        if (!rst_n_global_i) begin
            r_result    <= '0;
            r_result_ch <= '0;
        end else if (r_state == S_DONE) begin
            r_result    <= w_acc_cur;
            r_result_ch <= r_ch;
        end
    end

    assign result_o    = (r_state == S_DONE) ? w_acc_cur : r_result;
    assign result_ch_o = (r_state == S_DONE) ? r_ch : r_result_ch;
    assign rd_data_o   = r_acc[rd_ch_i];

endmodule

// File: tb/tb_cv32e40p_mac_acc.sv
// Randomised self-checking bench for cv32e40p_mac_acc against an arithmetic reference model.
// Expectations follow CV32E40P_MAC_SAT_EN when it is defined for the build.
module tb_cv32e40p_mac_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic [1:0]  ch = '0;
    logic        keep = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        rv;
    logic [31:0] result;
    logic [1:0]  result_ch;
    logic [1:0]  rd_ch = '0;
    logic [31:0] rd_data;
    logic        sat;

    cv32e40p_mac_acc #(
        .DATA_W(32),
        .FRAC_W(16),
        .ACC_W (32),
        .NUM_CH(4),
        .CNT_W (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_global_i(rst_n),
        .clr_i         (clr),
        .start_i       (start),
        .len_i         (len),
        .ch_i          (ch),
        .keep_i        (keep),
        .valid_i       (valid),
        .ready_o       (ready),
        .a_i           (a),
        .b_i           (b),
        .busy_o        (busy),
        .result_valid_o(rv),
        .result_o      (result),
        .result_ch_o   (result_ch),
        .rd_ch_i       (rd_ch),
        .rd_data_o     (rd_data),
        .sat_o         (sat)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] acc_m [4];
    bit          sat_m;
    logic [31:0] last_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Q16.16 product, then accumulate with wrap or saturation at 32 bits.
    function automatic void model_add(input int c, input logic [31:0] x, input logic [31:0] y);
        longint p;
        longint s;
        p = longint'($signed(x)) * longint'($signed(y));
        s = p >>> 16;
`ifdef CV32E40P_MAC_SAT_EN
        begin
            longint maxv = 64'sd2147483647;
            longint minv = -64'sd2147483648;
            longint t;
            if (s > maxv) begin s = maxv; sat_m = 1'b1; end
            if (s < minv) begin s = minv; sat_m = 1'b1; end
            t = longint'($signed(acc_m[c])) + s;
            if (t > maxv) begin t = maxv; sat_m = 1'b1; end
            if (t < minv) begin t = minv; sat_m = 1'b1; end
            acc_m[c] = 32'(t);
        end
`else
        acc_m[c] = acc_m[c] + 32'(s);
`endif
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        return 32'($signed(r) >>> $urandom_range(20));
    endfunction

    task automatic check_rd();
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            #1;
            chk("rd_data", 64'(rd_data), 64'(acc_m[i]));
        end
        @(negedge clk);
    endtask

    // mode 0: random valid and operands; 1: back-to-back fixed operands; 2: valid toggling, random operands
    task automatic run_op(input int c, input int n, input bit kp, input int mode,
                          input logic [31:0] fa, input logic [31:0] fb);
        int sent;
        int guard;
        int lat;
        bit v;
        start = 1'b1;
        ch    = 2'(c);
        len   = 16'(n);
        keep  = kp;
        if (!kp) begin
            acc_m[c] = '0;
            sat_m    = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 200) begin
            chk("ready", 64'(ready), 64'(1));
            chk("busy_acc", 64'(busy), 64'(1));
            chk("rv_early", 64'(rv), 64'(0));
            case (mode)
                0:       v = ($urandom_range(3) != 0);
                1:       v = 1'b1;
                default: v = (guard % 2 == 0);
            endcase
            a     = (mode == 1) ? fa : rand_op();
            b     = (mode == 1) ? fb : rand_op();
            valid = v;
            if (v) begin
                model_add(c, a, b);
                sent++;
            end
            @(negedge clk);
            guard++;
        end
        valid = 1'b0;
        if (sent < n) chk("accept_timeout", 64'(sent), 64'(n));
        lat = 1;
        while (!rv && lat < 12) begin
            chk("busy_wait", 64'(busy), 64'(1));
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'((n == 0) ? 1 : 3));
        chk("result", 64'(result), 64'(acc_m[c]));
        chk("result_ch", 64'(result_ch), 64'(c));
        chk("sat", 64'(sat), 64'(sat_m));
        last_res = acc_m[c];
        @(negedge clk);
        chk("rv_single", 64'(rv), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("result_hold", 64'(result), 64'(last_res));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        sat_m    = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rv", 64'(rv), 64'(0));
        chk("rst_sat", 64'(sat), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_result_ch", 64'(result_ch), 64'(0));
        check_rd();
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1, 3, 1'b0, 1, 32'h0002_0000, 32'h0001_8000);
        chk("tp_dot3", 64'(result), 64'(32'h0009_0000));
        run_op(2, 1, 1'b0, 1, 32'hFFFF_0000, 32'h0002_0000);
        chk("tp_neg", 64'(result), 64'(32'hFFFE_0000));
        run_op(2, 1, 1'b1, 1, 32'hFFFF_0000, 32'h0002_0000);
        chk("tp_keep", 64'(result), 64'(32'hFFFC_0000));
        rd_ch = 2'd1;
        #1;
        chk("tp_rd_ch1", 64'(rd_data), 64'(32'h0009_0000));
        check_rd();

        run_op(3, 4, 1'b0, 2, '0, '0);
        check_rd();

        run_op(0, 2, 1'b0, 1, 32'h7FFF_0000, 32'h7FFF_0000);
`ifdef CV32E40P_MAC_SAT_EN
        chk("tp_sat_val", 64'(result), 64'(32'h7FFF_FFFF));
        chk("tp_sat_flag", 64'(sat), 64'(1));
`else
        chk("tp_wrap_val", 64'(result), 64'(32'h0002_0000));
        chk("tp_wrap_flag", 64'(sat), 64'(0));
`endif

        // clear part-way through a 4-pair operation
        start = 1'b1;
        ch    = 2'd0;
        len   = 16'd4;
        keep  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            valid = 1'b1;
            a     = rand_op();
            b     = rand_op();
            @(negedge clk);
        end
        valid = 1'b0;
        clr   = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        sat_m = 1'b0;
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_sat", 64'(sat), 64'(0));
        chk("clr_result_hold", 64'(result), 64'(last_res));
        for (int i = 0; i < 4; i++) begin
            chk("clr_no_rv", 64'(rv), 64'(0));
            @(negedge clk);
        end
        check_rd();
        run_op(1, 2, 1'b0, 0, '0, '0);

        run_op(2, 0, 1'b0, 0, '0, '0);
        chk("tp_len0", 64'(result), 64'(0));
        run_op(1, 0, 1'b1, 0, '0, '0);

        for (int k = 0; k < 20; k++) begin
            run_op(int'($urandom_range(3)), int'($urandom_range(6)), 1'($urandom_range(1)),
                   ($urandom_range(1) == 0) ? 0 : 2, '0, '0);
            check_rd();
        end

        // asynchronous reset in the middle of accumulation
        start = 1'b1;
        ch    = 2'd3;
        len   = 16'd5;
        keep  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b1;
        a     = rand_op();
        b     = rand_op();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        valid = 1'b0;
        chk("arst_ready", 64'(ready), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_rv", 64'(rv), 64'(0));
        chk("arst_result", 64'(result), 64'(0));
        chk("arst_result_ch", 64'(result_ch), 64'(0));
        chk("arst_sat", 64'(sat), 64'(0));
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        sat_m    = 1'b0;
        last_res = '0;
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            #1;
            chk("arst_rd", 64'(rd_data), 64'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3, 3, 1'b0, 0, '0, '0);
        check_rd();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
